// File: rtl/lcd_phy_pkg.sv
// Shared types, constants and helpers for the parametrised HD44780 physical layer.
package lcd_phy_pkg;

    // Controller states; exported on the debug port of lcd_phy_param.
    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        INIT_STROBE,
        INIT_WAIT,
        SETUP,
        E_HIGH,
        NIB_GAP,
        POST_WAIT
    } state_t;

    // Fixed waits of the HD44780 reset-by-instruction sequence.
    localparam int unsigned T_INIT1_US = 4100;
    localparam int unsigned T_INIT2_US = 100;

    // Nibble values used during init: 0x3 selects 8-bit, 0x2 switches to 4-bit.
    localparam logic [3:0] INIT_NIB  = 4'h3;
    localparam logic [3:0] FUNC4_NIB = 4'h2;

    // Microseconds to clock cycles; CLK_HZ is a whole number of MHz.
    function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_phy_param_if.sv
// Byte transfer channel between the LCD command/text controller and the PHY.
//
// Handshake: the master raises tx_valid with tx_data/tx_rs stable; the byte is
// taken on the rising clk edge where tx_valid && tx_ready are both high. The
// master must keep tx_valid, tx_data and tx_rs unchanged until that edge and may
// change them freely afterwards. tx_ready never depends on tx_valid. tx_done is a
// one-cycle pulse when the byte's post-transfer wait has elapsed.
interface lcd_phy_param_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_rs;
    logic       tx_done;

    modport master (output tx_valid, output tx_data, output tx_rs,
                    input  tx_ready, input  tx_done);
    modport slave  (input  tx_valid, input  tx_data, input  tx_rs,
                    output tx_ready, output tx_done);
endinterface

// File: rtl/lcd_delay_timer.sv
// Load/count/done down-counter shared by every wait and strobe phase.
// Loading N makes done assert during the Nth cycle after the load edge.
module lcd_delay_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Count down to zero; a load always wins so back-to-back phases chain cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_phy_param.sv
// HD44780-class LCD physical layer: power-on init, 4/8-bit strobing, timed waits.
module lcd_phy_param
    import lcd_phy_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int          BUS_WIDTH    = 4,
    parameter int unsigned T_POWERON_US = 15000,
    parameter int unsigned T_SETUP_CYC  = 2,
    parameter int unsigned T_EHIGH_CYC  = 12,
    parameter int unsigned T_NIBGAP_US  = 1,
    parameter int unsigned T_CMD_US     = 40,
    parameter int unsigned T_LONG_US    = 1640,
    parameter int          CNT_W        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init_req,
    output logic                 init_done,
    lcd_phy_param_if.slave       tx,
    output logic                 busy,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic [BUS_WIDTH-1:0] lcd_db,
    output state_t               dbg_state
);

    generate
        if ((BUS_WIDTH != 4) && (BUS_WIDTH != 8)) begin : g_bad_width
            $error("lcd_phy_param: BUS_WIDTH must be 4 or 8");
        end
        if ((CLK_HZ % 1_000_000) != 0) begin : g_bad_clk
            $error("lcd_phy_param: CLK_HZ must be a multiple of 1 MHz");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CYC_PWR    = CNT_W'(us_to_cyc(CLK_HZ, T_POWERON_US));
    localparam logic [CNT_W-1:0] CYC_INIT1  = CNT_W'(us_to_cyc(CLK_HZ, T_INIT1_US));
    localparam logic [CNT_W-1:0] CYC_INIT2  = CNT_W'(us_to_cyc(CLK_HZ, T_INIT2_US));
    localparam logic [CNT_W-1:0] CYC_CMD    = CNT_W'(us_to_cyc(CLK_HZ, T_CMD_US));
    localparam logic [CNT_W-1:0] CYC_LONG   = CNT_W'(us_to_cyc(CLK_HZ, T_LONG_US));
    localparam logic [CNT_W-1:0] CYC_NIBGAP = CNT_W'(us_to_cyc(CLK_HZ, T_NIBGAP_US));
    localparam logic [CNT_W-1:0] CYC_SETUP  = CNT_W'(T_SETUP_CYC);
    localparam logic [CNT_W-1:0] CYC_EHIGH  = CNT_W'(T_EHIGH_CYC);

    // 4-bit mode needs a fourth init strobe to switch the panel to 4-bit.
    localparam logic [1:0] LAST_STEP = (BUS_WIDTH == 4) ? 2'd3 : 2'd2;

    // Init strobe values as they appear on the bus (DB7..DB4 in 4-bit mode).
    localparam logic [BUS_WIDTH-1:0] INIT_VAL  = (BUS_WIDTH == 8) ? BUS_WIDTH'({INIT_NIB, 4'h0})
                                                                  : BUS_WIDTH'(INIT_NIB);
    localparam logic [BUS_WIDTH-1:0] FUNC4_VAL = BUS_WIDTH'(FUNC4_NIB);

    state_t               state, state_next;
    logic [1:0]           init_step, step_next;
    logic                 nib_lo, nib_lo_next;
    logic                 in_init, in_init_next;
    logic [7:0]           lat_data;
    logic                 lat_rs;
    logic                 tx_done_q;
    logic                 init_done_next, tx_done_next;
    logic                 latch_en;
    logic                 bus_load;
    logic [BUS_WIDTH-1:0] bus_val;
    logic                 bus_rs;
    logic                 tmr_load, tmr_done;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tx_ready_int, accept;

    assign tx_ready_int = (state == IDLE) && init_done && !init_req;
    assign accept       = tx.tx_valid && tx_ready_int;
    assign tx.tx_ready  = tx_ready_int;
    assign tx.tx_done   = tx_done_q;
    assign busy         = (state != IDLE);
    assign lcd_rw       = 1'b0;
    assign dbg_state    = state;

    lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register plus sequencing bookkeeping; reset abandons any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            init_step <= 2'd0;
            nib_lo    <= 1'b0;
            in_init   <= 1'b0;
        end else begin
            state     <= state_next;
            init_step <= step_next;
            nib_lo    <= nib_lo_next;
            in_init   <= in_init_next;
        end
    end

    // Next state, timer loads and bus updates; every phase is one timer load.
    always_comb begin
        state_next     = state;
        step_next      = init_step;
        nib_lo_next    = nib_lo;
        in_init_next   = in_init;
        init_done_next = init_done;
        tx_done_next   = 1'b0;
        latch_en       = 1'b0;
        bus_load       = 1'b0;
        bus_val        = '0;
        bus_rs         = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_next     = PWR_WAIT;
                    init_done_next = 1'b0;
                    in_init_next   = 1'b1;
                    step_next      = 2'd0;
                    tmr_load       = 1'b1;
                    tmr_val        = CYC_PWR;
                end else if (accept) begin
                    state_next   = SETUP;
                    in_init_next = 1'b0;
                    nib_lo_next  = 1'b0;
                    latch_en     = 1'b1;
                    bus_load     = 1'b1;
                    bus_rs       = tx.tx_rs;
                    bus_val      = (BUS_WIDTH == 8) ? BUS_WIDTH'(tx.tx_data)
                                                    : BUS_WIDTH'(tx.tx_data[7:4]);
                    tmr_load     = 1'b1;
                    tmr_val      = CYC_SETUP;
                end
            end
            PWR_WAIT: begin
                if (tmr_done) begin
                    state_next = INIT_STROBE;
                    bus_load   = 1'b1;
                    bus_val    = INIT_VAL;
                    tmr_load   = 1'b1;
                    tmr_val    = CYC_SETUP;
                end
            end
            INIT_STROBE, SETUP: begin
                if (tmr_done) begin
                    state_next = E_HIGH;
                    tmr_load   = 1'b1;
                    tmr_val    = CYC_EHIGH;
                end
            end
            E_HIGH: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (in_init) begin
                        state_next = INIT_WAIT;
                        case (init_step)
                            2'd0:    tmr_val = CYC_INIT1;
                            2'd1:    tmr_val = CYC_INIT2;
                            default: tmr_val = CYC_CMD;
                        endcase
                    end else if ((BUS_WIDTH == 4) && !nib_lo) begin
                        state_next = NIB_GAP;
                        tmr_val    = CYC_NIBGAP;
                    end else begin
                        state_next = POST_WAIT;
                        tmr_val    = is_long_cmd(lat_rs, lat_data) ? CYC_LONG : CYC_CMD;
                    end
                end
            end
            NIB_GAP: begin
                if (tmr_done) begin
                    state_next  = SETUP;
                    nib_lo_next = 1'b1;
                    bus_load    = 1'b1;
                    bus_rs      = lat_rs;
                    bus_val     = BUS_WIDTH'(lat_data[3:0]);
                    tmr_load    = 1'b1;
                    tmr_val     = CYC_SETUP;
                end
            end
            INIT_WAIT: begin
                if (tmr_done) begin
                    if (init_step == LAST_STEP) begin
                        state_next     = IDLE;
                        init_done_next = 1'b1;
                        in_init_next   = 1'b0;
                    end else begin
                        state_next = INIT_STROBE;
                        step_next  = init_step + 2'd1;
                        bus_load   = 1'b1;
                        bus_val    = (init_step == 2'd2) ? FUNC4_VAL : INIT_VAL;
                        tmr_load   = 1'b1;
                        tmr_val    = CYC_SETUP;
                    end
                end
            end
            POST_WAIT: begin
                if (tmr_done) begin
                    state_next   = IDLE;
                    tx_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered pins and byte latch; E is a clean decode of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= '0;
            init_done <= 1'b0;
            tx_done_q <= 1'b0;
            lat_data  <= 8'h00;
            lat_rs    <= 1'b0;
        end else begin
            lcd_e     <= (state_next == E_HIGH);
            init_done <= init_done_next;
            tx_done_q <= tx_done_next;
            if (bus_load) begin
                lcd_db <= bus_val;
                lcd_rs <= bus_rs;
            end
            if (latch_en) begin
                lat_data <= tx.tx_data;
                lat_rs   <= tx.tx_rs;
            end
        end
    end

endmodule

// File: doc/lcd_phy_param.md
Name: lcd_phy_param

Overview:
Parametrised HD44780-class LCD physical layer, successor to the fixed 4-bit LCD driver. Supports 4-bit or 8-bit bus mode, derives all delays from CLK_HZ, and uses a valid/ready byte interface. Adds power-on wait, re-init, a long-command wait for clear/home, and a tx_done pulse. Sits between the LCD command/text controller and the FPGA pins.

Parameters:
CLK_HZ, 50_000_000, clk frequency; must be a multiple of 1_000_000.
BUS_WIDTH, 4, LCD data bus width; legal values are 4 or 8 (elaboration error otherwise).
T_POWERON_US, 15000, wait after init_req before the first strobe.
T_SETUP_CYC, 2, cycles RS/DB are stable with E low before E rises.
T_EHIGH_CYC, 12, E high width in cycles.
T_NIBGAP_US, 1, gap between high and low nibble in 4-bit mode.
T_CMD_US, 40, post-transfer wait for normal commands/data.
T_LONG_US, 1640, post-transfer wait for clear/home.
CNT_W, 20, delay counter width; must hold CLK_HZ/1e6*max(T_*_US, 4100).

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  asynchronous, active-high.
init_req  in  1  level; starts the init sequence when sampled in IDLE.
init_done  out  1  sticky high after init completes; cleared at init start.
tx_valid  in  1  byte transfer request.
tx_ready  out  1  equals IDLE & init_done & ~init_req; a transfer is accepted when tx_valid & tx_ready.
tx_data  in  8  byte to send; captured on accept.
tx_rs  in  1  register select for the byte; captured on accept.
tx_done  out  1  one-cycle pulse when the post-transfer wait ends.
busy  out  1  high in any state other than IDLE.
lcd_e  out  1  enable strobe.
lcd_rs  out  1  register select.
lcd_rw  out  1  constant 0; the block only writes.
lcd_db  out  BUS_WIDTH  data bus; maps to DB7..DB4 when BUS_WIDTH=4.

Behaviour:
- Reset: lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, tx_done, busy, tx_ready all 0; state IDLE. lcd_e drops immediately (asynchronous) if reset is asserted mid-strobe; any in-progress transfer is abandoned.
- Delay conversion: cyc(us) = (CLK_HZ/1_000_000)*us, computed at elaboration. The shared timer loads N and signals done after exactly N cycles.
- Strobe(v): drive lcd_db=v and lcd_rs for T_SETUP_CYC cycles with E=0, then E=1 for T_EHIGH_CYC cycles, then E=0. lcd_db and lcd_rs hold their values until the next strobe's setup phase.
- States: IDLE, PWR_WAIT, INIT_STROBE, INIT_WAIT, SETUP, E_HIGH, NIB_GAP, POST_WAIT.
- IDLE: if init_req, clear init_done and go to PWR_WAIT. init_req has priority over tx_valid in the same cycle; tx_ready is 0 then.
- Init, lcd_rs=0 throughout:
  - Wait cyc(T_POWERON_US).
  - Strobe 3 (BUS_WIDTH=4) or 0x30 (BUS_WIDTH=8), then wait cyc(4100).
  - Same strobe, then wait cyc(100).
  - Same strobe, then wait cyc(T_CMD_US).
  - BUS_WIDTH=4 only: strobe 2, then wait cyc(T_CMD_US).
  - Then set init_done=1 and return to IDLE. No tx_done pulse for init.
- Transfer: on accept, latch tx_data and tx_rs; lcd_rs follows the latch from the first setup cycle.
  - BUS_WIDTH=8: one strobe of tx_data.
  - BUS_WIDTH=4: strobe tx_data[7:4], NIB_GAP for cyc(T_NIBGAP_US), then strobe tx_data[3:0].
  - Then POST_WAIT for cyc(T_LONG_US) if rs=0 and data is 0x01, 0x02 or 0x03; otherwise cyc(T_CMD_US).
  - At the end of POST_WAIT: pulse tx_done for one cycle and enter IDLE. tx_ready rises the same cycle if init_req is low.
- tx_valid before init_done is never accepted and is held off. tx_data/tx_rs changes after accept have no effect.
- init_req while busy is ignored until IDLE (level-sampled).

Decomposition:
- Package lcd_phy_pkg: state enum; us_to_cyc function; constants T_INIT1_US=4100, T_INIT2_US=100, INIT_NIB=4'h3, FUNC4_NIB=4'h2; is_long_cmd(rs,data) function.
- One sub-module lcd_delay_timer: load/count/done down-counter of width CNT_W, reused for every wait and strobe phase.

Test Plan:
1. BUS_WIDTH=4, CLK_HZ=1MHz, T_POWERON_US=20, init_req pulse -> exactly four E pulses with lcd_db 3,3,3,2; E-rise spacing: 4100/100/40 µs waits plus strobe cycles each; init_done rises after the final 40-cycle wait; lcd_rs=0 throughout.
2. After init, send tx_data=0x48 with tx_rs=1 -> lcd_db 4 then 8, each E high 12 cycles; NIB_GAP 1 cycle; 40-cycle post-wait; one tx_done pulse; tx_ready low from accept until tx_done.
3. Send 0x01 with rs=0 -> POST_WAIT lasts 1640 cycles. Send 0x01 with rs=1 -> POST_WAIT lasts 40 cycles.
4. BUS_WIDTH=8 instance -> init strobes 0x30 three times, no fourth strobe; byte 0xA5 sent as a single strobe with lcd_db=0xA5.
5. tx_valid held before init_done -> no E activity, tx_ready=0; init_req and tx_valid together in IDLE after init -> init runs, byte accepted only after the new init_done.
6. Assert reset during E_HIGH of the second nibble -> lcd_e=0 asynchronously, all outputs at reset values; a new init_req after reset completes normally.
